// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch unit with PC, ROM interface and 2-entry prefetch buffer
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  logic [31:0] pc;
  logic [31:0] buf_pc    [2];
  logic [31:0] buf_instr [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic        pop;
  logic        fill;

  // ROM address is always the word-aligned PC; low bits never reach the ROM
  assign rom_addr = {pc[31:2], 2'b00};

  // Head of the buffer is registered storage only, so it holds steady under backpressure
  assign out_valid = (count != 2'd0);
  assign out_instr = buf_instr[rd_ptr];
  assign out_pc    = buf_pc[rd_ptr];

  // A full buffer may still accept a word when the head leaves in the same cycle
  assign pop  = out_valid && out_ready;
  assign fill = fetch_en && !redirect_valid && ((count < 2'd2) || pop);

  // PC, pointers and occupancy; a redirect flushes everything including a coincident pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= {RESET_PC[31:2], 2'b00};
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (redirect_valid) begin
      pc     <= {redirect_pc[31:2], 2'b00};
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (fill) begin
        pc     <= {pc[31:2], 2'b00} + 32'd4;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({fill, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Buffer entries capture {pc, rom_data} on a fill; cleared on reset so outputs read zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_pc[0]    <= 32'd0;
      buf_pc[1]    <= 32'd0;
      buf_instr[0] <= 32'd0;
      buf_instr[1] <= 32'd0;
    end else if (fill) begin
      buf_pc[wr_ptr]    <= {pc[31:2], 2'b00};
      buf_instr[wr_ptr] <= rom_data;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized self-checking bench for instruction_fetch
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int total;
  int bad;

  // reference state: fetch pointer and queue of {pc, instr} pairs awaiting decode
  logic [31:0] m_pc;
  logic [63:0] m_q[$];

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    logic [31:0] w;
    w = addr >> 2;
    if (w == 32'd0)      return 32'h0030_6093;
    else if (w == 32'd1) return 32'h0040_A113;
    else                 return (w * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  assign rom_data = rom_word(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("rom_addr", rom_addr, m_pc);
    chk("out_valid", {31'd0, out_valid}, {31'd0, (m_q.size() != 0)});
    if (m_q.size() != 0) begin
      chk("out_pc", out_pc, m_q[0][63:32]);
      chk("out_instr", out_instr, m_q[0][31:0]);
    end
  endtask

  // drive one cycle of inputs, advance the model, then check after the edge
  task automatic cycle(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy);
    bit popped;
    int depth;
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    depth  = m_q.size();
    popped = (depth != 0) && rdy;
    if (rv) begin
      m_q.delete();
      m_pc = rpc & 32'hFFFF_FFFC;
    end else begin
      if (popped) void'(m_q.pop_front());
      if (fe && (depth < 2 || popped)) begin
        m_q.push_back({m_pc, rom_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc = 32'h0000_0000;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    fetch_en = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    out_ready = 1'b0;
    model_reset();

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_rom_addr", rom_addr, 32'd0);
    rst_n = 1'b1;

    // first two words with decode always ready
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    chk("c1_pc", out_pc, 32'h0);
    chk("c1_instr", out_instr, 32'h0030_6093);
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    chk("c2_pc", out_pc, 32'h4);
    chk("c2_instr", out_instr, 32'h0040_A113);

    // backpressure after a fresh reset: buffer saturates at two
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'd0, 1'b0);
    chk("sat_rom_addr", rom_addr, 32'h8);
    chk("sat_out_pc", out_pc, 32'h0);
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    chk("drain_pc4", out_pc, 32'h4);
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    chk("drain_pc8", out_pc, 32'h8);

    // redirect to a misaligned target while full
    cycle(1'b1, 1'b0, 32'd0, 1'b0);
    cycle(1'b1, 1'b1, 32'h0000_0031, 1'b0);
    chk("redir_valid", {31'd0, out_valid}, 32'd0);
    chk("redir_rom_addr", rom_addr, 32'h30);
    cycle(1'b1, 1'b0, 32'd0, 1'b0);
    chk("redir_out_pc", out_pc, 32'h30);

    // redirect coincident with pop at one entry
    cycle(1'b1, 1'b1, 32'h0000_0100, 1'b1);
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    cycle(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    chk("flush_pop_valid", {31'd0, out_valid}, 32'd0);
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    chk("flush_pop_pc", out_pc, 32'h200);

    // wrap across the top of the address space
    cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    chk("wrap0", out_pc, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    chk("wrap1", out_pc, 32'h0);
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    chk("wrap2", out_pc, 32'h4);

    // fetch disabled drains the buffer and freezes the PC
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);
    chk("fe_off_valid", {31'd0, out_valid}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      cycle(($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0), tgt,
            ($urandom_range(0, 3) != 0));
    end

    // asynchronous reset between edges
    cycle(1'b1, 1'b0, 32'd0, 1'b0);
    cycle(1'b1, 1'b0, 32'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rom_addr", rom_addr, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    chk("post_rst_pc", out_pc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
